// File: rtl/ocsim_axim_responder.sv
// AXI4 slave responder backed by a word-addressed memory, for block-level benches.
// Optional random stalls and protocol checks: OCSIM_AXIM_RESPONDER_RANDOM_STALL_EN.

package oclib_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi4m_a_s;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi4m_64_w_s;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi4m_b_s;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi4m_64_r_s;

    typedef struct packed {
        axi4m_a_s    aw;
        axi4m_a_s    ar;
        axi4m_64_w_s w;
        logic        awvalid;
        logic        arvalid;
        logic        wvalid;
        logic        bready;
        logic        rready;
    } axi4m_64_s;

    typedef struct packed {
        logic        awready;
        logic        arready;
        logic        wready;
        axi4m_b_s    b;
        axi4m_64_r_s r;
        logic        bvalid;
        logic        rvalid;
    } axi4m_64_fb_s;

endpackage

module ocsim_axim_responder #(
    parameter type AxiType = oclib_pkg::axi4m_64_s,
    parameter type AxiFbType = oclib_pkg::axi4m_64_fb_s,
    parameter int MemDepth = 256,
    parameter longint unsigned BaseAddress = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$bits(AxiType)-1:0]   axi,
    output logic [$bits(AxiFbType)-1:0] axiFb
);

    AxiType   req;
    AxiFbType fb;

    assign req   = axi;
    assign axiFb = fb;

    localparam int DataWidth = $bits(req.w.data);
    localparam int Bytes     = DataWidth / 8;
    localparam int ByteW     = $clog2(Bytes);
    localparam int AddrWidth = $bits(req.aw.addr);
    localparam int IdW       = $bits(req.aw.id);
    localparam int LenW      = $bits(req.aw.len);
    localparam int IdxW      = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [63:0] Lo = 64'(BaseAddress);
    localparam logic [63:0] Hi = Lo + 64'(MemDepth) * 64'(Bytes);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e w_state;
    rstate_e r_state;

    logic [DataWidth-1:0] mem [MemDepth] = '{default: '0};

    logic [AddrWidth-1:0] w_addr, r_addr;
    logic [IdW-1:0]       w_id, r_id;
    logic [LenW-1:0]      w_len, w_beat, r_len, r_beat;
    logic [1:0]           w_burst, r_burst, b_resp_q, r_resp_q;
    logic                 w_err;
    logic                 awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
    logic [DataWidth-1:0] r_data_q;
    logic                 r_last_q;
    logic                 go_aw, go_w, go_ar;
    logic [2:0]           b_rnd, r_rnd, b_wait, r_wait;

    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        logic [63:0] a64;
        a64 = 64'(a);
        return (a64 >= Lo) && (a64 < Hi);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] a);
        return IdxW'((64'(a) - Lo) >> ByteW);
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(
        input logic [AddrWidth-1:0] a, input logic [1:0] burst);
        return (burst == 2'd0) ? a : a + AddrWidth'(Bytes);
    endfunction

    function automatic logic [1:0] beat_resp(
        input logic [AddrWidth-1:0] a, input logic [1:0] burst);
        if (!in_range(a)) return 2'd3;
        if (burst == 2'd2) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [DataWidth-1:0] rd(input logic [AddrWidth-1:0] a);
        return in_range(a) ? mem[word_idx(a)] : '0;
    endfunction

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, w_last_beat, mem_we;
    logic [IdxW-1:0] w_idx;

    assign aw_fire     = req.awvalid & awready_q;
    assign w_fire      = req.wvalid & wready_q;
    assign b_fire      = bvalid_q & req.bready;
    assign ar_fire     = req.arvalid & arready_q;
    assign r_fire      = rvalid_q & req.rready;
    assign w_last_beat = (w_beat == w_len);
    assign w_idx       = word_idx(w_addr);
    assign mem_we      = !reset && w_state == W_DATA && w_fire
                         && in_range(w_addr) && w_burst != 2'd2;

    logic unused_ok;
    assign unused_ok = ^{req.aw.size, req.ar.size, req.w.last};

`ifdef OCSIM_AXIM_RESPONDER_RANDOM_STALL_EN
`ifndef OC_ASSERT
`define OC_ASSERT(cond) assert (cond)
`endif
    logic aw_hold, w_hold, ar_hold;

    // Fresh random ready gates and response delays every cycle
    always_ff @(posedge clock) begin
        go_aw <= $urandom_range(3, 0) != 0;
        go_w  <= $urandom_range(3, 0) != 0;
        go_ar <= $urandom_range(3, 0) != 0;
        b_rnd <= 3'($urandom_range(7, 0));
        r_rnd <= 3'($urandom_range(7, 0));
    end

    // Master-side protocol checks: stable valids and matching w.last
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_hold <= 1'b0;
            w_hold  <= 1'b0;
            ar_hold <= 1'b0;
        end else begin
            if (aw_hold) `OC_ASSERT(req.awvalid);
            if (w_hold) `OC_ASSERT(req.wvalid);
            if (ar_hold) `OC_ASSERT(req.arvalid);
            if (w_state == W_DATA && w_fire) `OC_ASSERT(req.w.last == w_last_beat);
            aw_hold <= req.awvalid && !awready_q;
            w_hold  <= req.wvalid && !wready_q;
            ar_hold <= req.arvalid && !arready_q;
        end
    end
`else
    assign go_aw = 1'b1;
    assign go_w  = 1'b1;
    assign go_ar = 1'b1;
    assign b_rnd = 3'd0;
    assign r_rnd = 3'd0;
`endif

    // Backing store: byte-strobed writes, never reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < Bytes; i++) begin
                if (req.w.strb[i]) mem[w_idx][i*8 +: 8] <= req.w.data[i*8 +: 8];
            end
        end
    end

    // Write channel FSM: AW capture, W beats, then held B response
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_id      <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_burst   <= '0;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            b_resp_q  <= '0;
            b_wait    <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_addr    <= req.aw.addr;
                        w_id      <= req.aw.id;
                        w_len     <= req.aw.len;
                        w_burst   <= req.aw.burst;
                        w_beat    <= '0;
                        w_err     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= go_w;
                        w_state   <= W_DATA;
                    end else begin
                        awready_q <= go_aw;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_burst);
                        w_beat <= w_beat + 1'b1;
                        if (!in_range(w_addr)) w_err <= 1'b1;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            b_resp_q <= (w_err || !in_range(w_addr)) ? 2'd3 :
                                        (w_burst == 2'd2) ? 2'd2 : 2'd0;
                            bvalid_q <= (b_rnd == 3'd0);
                            b_wait   <= b_rnd;
                            w_state  <= W_RESP;
                        end else begin
                            wready_q <= go_w;
                        end
                    end else begin
                        wready_q <= go_w;
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= go_aw;
                        w_state   <= W_IDLE;
                    end else if (!bvalid_q) begin
                        b_wait <= b_wait - 3'd1;
                        if (b_wait == 3'd1) bvalid_q <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: AR capture, then one registered R beat per handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_burst   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
            r_wait    <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_addr    <= next_addr(req.ar.addr, req.ar.burst);
                        r_id      <= req.ar.id;
                        r_len     <= req.ar.len;
                        r_burst   <= req.ar.burst;
                        r_beat    <= '0;
                        r_data_q  <= rd(req.ar.addr);
                        r_resp_q  <= beat_resp(req.ar.addr, req.ar.burst);
                        r_last_q  <= (req.ar.len == '0);
                        arready_q <= 1'b0;
                        rvalid_q  <= (r_rnd == 3'd0);
                        r_wait    <= r_rnd;
                        r_state   <= R_DATA;
                    end else begin
                        arready_q <= go_ar;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_last_q) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= go_ar;
                            r_state   <= R_IDLE;
                        end else begin
                            r_data_q <= rd(r_addr);
                            r_resp_q <= beat_resp(r_addr, r_burst);
                            r_last_q <= (r_beat + 1'b1 == r_len);
                            r_beat   <= r_beat + 1'b1;
                            r_addr   <= next_addr(r_addr, r_burst);
                            rvalid_q <= (r_rnd == 3'd0);
                            r_wait   <= r_rnd;
                        end
                    end else if (!rvalid_q) begin
                        r_wait <= r_wait - 3'd1;
                        if (r_wait == 3'd1) rvalid_q <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Pack registered channel state into the feedback bundle
    always_comb begin
        fb         = '0;
        fb.awready = awready_q;
        fb.wready  = wready_q;
        fb.arready = arready_q;
        fb.bvalid  = bvalid_q;
        fb.b.id    = w_id;
        fb.b.resp  = b_resp_q;
        fb.rvalid  = rvalid_q;
        fb.r.id    = r_id;
        fb.r.data  = r_data_q;
        fb.r.resp  = r_resp_q;
        fb.r.last  = r_last_q;
    end

endmodule

// File: doc/ocsim_axim_responder.md
Name: ocsim_axim_responder

Overview:
Simulation-side AXI4 slave that answers transactions issued by an AXI master model or DUT master port. It is backed by an internal word-addressed memory. Write (AW/W/B) and read (AR/R) channels run independent state machines, support single-beat and INCR/FIXED bursts, and echo IDs. It provides the far end for register/memory traffic in block-level benches.

Parameters:
AxiType, oclib_pkg::axi4m_64_s, master-to-slave struct (aw, ar, w, valids, bready, rready)
AxiFbType, oclib_pkg::axi4m_64_fb_s, slave-to-master struct (readies, b, r, bvalid, rvalid)
MemDepth, 256, number of DataWidth-bit words in backing memory
BaseAddress, 0, byte address mapped to memory word 0

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
axi  input  $bits(AxiType)  requests from master
axiFb  output  $bits(AxiFbType)  readies and responses to master

Behaviour:
- Derived: DataWidth = $bits(axi.w.data); Bytes = DataWidth/8; word index = (addr - BaseAddress) / Bytes.
- Address in range iff BaseAddress <= addr < BaseAddress + MemDepth*Bytes. Otherwise the beat is DECERR (resp=3): no memory write, read data 0.
- Reset: every axiFb field is 0. Both FSMs go to IDLE. Memory contents are not reset; they are initialised to 0 at time zero only.
- Reset mid-operation: the outstanding transaction is dropped and no B or R is issued for it. awready/arready assert the first cycle after reset deasserts.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, capture addr, id, len, burst; move to W_DATA.
  - W_DATA: wready=1. For each W handshake, write the bytes whose strb bit is 1. Address advances by Bytes for INCR (burst=1) and stays fixed for FIXED (burst=0).
  - W_DATA exits after len+1 beats. The beat count governs; w.last is checked against it (see Optional Feature).
  - W_RESP: bvalid=1, b.id = captured id. b.resp = 3 if any beat was out of range, 2 if burst=2 (WRAP: strobes ignored, no memory writes), else 0. Return to W_IDLE on B handshake.
  - awready is 0 outside W_IDLE. One write is outstanding at a time.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture fields; move to R_DATA.
  - R_DATA: rvalid=1, r.id = captured id, r.data = memory word registered from the current beat address. r.last=1 only on beat len. Per-beat resp uses the same rules as writes.
  - Each R handshake advances the beat. The next beat is presented the following cycle, so back-to-back beats are allowed.
  - After the last handshake, return to R_IDLE.
- Latency:
  - AW handshake at cycle N -> wready at N+1.
  - Final W handshake at M -> bvalid at M+1.
  - AR handshake at N -> first rvalid at N+1.
- Unaccepted B/R: valid and payload stay stable until ready. No AXI signal depends combinationally on the master's valid/ready.
- Read/write collision: a write committed at cycle N is visible to read beats registered at N+1 or later.
- Narrow size: strobes alone select bytes; size is not used for addressing beyond Bytes stride.

Optional Feature:
OCSIM_AXIM_RESPONDER_RANDOM_STALL_EN
- Defined:
  - Each cycle, awready/wready/arready are independently deasserted with probability 1/4 via $urandom.
  - bvalid/rvalid assertion is delayed 0-7 random cycles.
  - Protocol-check `OC_ASSERTs are enabled: w.last must match the final beat; valid must not drop before handshake.
- Undefined: deterministic timing exactly as in Behaviour, and no assertions compiled.

Test Plan:
- Write: AW addr=0x10 id=5 len=0, W data lanes 0x00000000_DEADBEEF strb=0x0F -> bvalid one cycle after W handshake, b.resp=0, b.id=5.
- Read back: AR addr=0x10 id=3 -> r.data[31:0]=0xDEADBEEF, resp=0, last=1, id=3.
- Byte strobe: write 0xFFFFFFFF to 0x20 strb=0x0F, then 0x11223344 strb=0x01 -> read 0x20 returns 0xFFFFFF44.
- INCR burst: write 4 beats 0x0..0x3 at 0x40, then AR len=3 at 0x40 -> 4 consecutive R beats 0,1,2,3 with last only on beat 4, no gap cycles.
- Decode error: write to BaseAddress+MemDepth*8 (0x800) -> b.resp=3. Read of 0x800 -> resp=3, data=0. Memory at 0x0 unchanged.
- Backpressure/reset:
  - Hold bready=0 for 5 cycles -> bvalid and b stable, awready=0 throughout.
  - Assert reset during W_DATA -> no bvalid ever; awready=1 the cycle after reset drops.
